// File: rtl/mem_bist_master.sv
// Avalon-MM BIST master: fills a RAM range with seed+i or reads it back and counts mismatches.
// One access per cycle; read expectations travel through an RD_LAT-deep pipeline to the compare point.
module mem_bist_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W:0]     cmd_count,
    input  logic [DATA_W-1:0]   cmd_seed,
    input  logic                abort,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_clken,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                first_err_valid
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic [ADDR_W:0]     remain_q;
    logic [DATA_W-1:0]   pat_q;
    logic                m_chipselect_q;
    logic                m_write_q;
    logic [ADDR_W-1:0]   m_address_q;
    logic [DATA_W-1:0]   m_writedata_q;
    logic                cmd_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                aborted_q;
    logic [ADDR_W:0]     err_count_q;
    logic [ADDR_W-1:0]   first_err_addr_q;
    logic                first_err_valid_q;

    logic                pipe_vld_q [RD_LAT];
    logic [DATA_W-1:0]   pipe_dat_q [RD_LAT];
    logic [ADDR_W-1:0]   pipe_adr_q [RD_LAT];

    logic rd_issue;
    logic last_access;
    logic rd_mismatch;
    logic rd_pending;

    assign rd_issue    = m_chipselect_q & ~m_write_q;
    assign last_access = (remain_q == (ADDR_W+1)'(1)) | abort;
    assign rd_mismatch = pipe_vld_q[RD_LAT-1] && (m_readdata != pipe_dat_q[RD_LAT-1]);

    // Reads still in flight that will not be compared on the coming edge.
    always_comb begin
        rd_pending = 1'b0;
        for (int k = 0; k < RD_LAT - 1; k++) begin
            rd_pending = rd_pending | pipe_vld_q[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld_q[0] <= 1'b0;
            pipe_dat_q[0] <= '0;
            pipe_adr_q[0] <= '0;
        end else begin
            pipe_vld_q[0] <= rd_issue;
            pipe_dat_q[0] <= pat_q;
            pipe_adr_q[0] <= m_address_q;
        end
    end

    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pipe_vld_q[gi] <= 1'b0;
                pipe_dat_q[gi] <= '0;
                pipe_adr_q[gi] <= '0;
            end else begin
                pipe_vld_q[gi] <= pipe_vld_q[gi-1];
                pipe_dat_q[gi] <= pipe_dat_q[gi-1];
                pipe_adr_q[gi] <= pipe_adr_q[gi-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            remain_q          <= '0;
            pat_q             <= '0;
            m_chipselect_q    <= 1'b0;
            m_write_q         <= 1'b0;
            m_address_q       <= '0;
            m_writedata_q     <= '0;
            cmd_ready_q       <= 1'b1;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            aborted_q         <= 1'b0;
            err_count_q       <= '0;
            first_err_addr_q  <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rd_mismatch) begin
                err_count_q <= err_count_q + (ADDR_W+1)'(1);
                if (!first_err_valid_q) begin
                    first_err_valid_q <= 1'b1;
                    first_err_addr_q  <= pipe_adr_q[RD_LAT-1];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_q       <= 1'b0;
                        busy_q            <= 1'b1;
                        err_count_q       <= '0;
                        first_err_valid_q <= 1'b0;
                        aborted_q         <= 1'b0;
                        remain_q          <= cmd_count;
                        pat_q             <= cmd_seed;
                        if (cmd_count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q        <= cmd_op ? S_READ : S_WRITE;
                            m_chipselect_q <= 1'b1;
                            m_write_q      <= ~cmd_op;
                            m_address_q    <= cmd_base;
                            m_writedata_q  <= cmd_op ? '0 : cmd_seed;
                        end
                    end
                end
                S_WRITE, S_READ: begin
                    if (last_access) begin
                        m_chipselect_q <= 1'b0;
                        m_write_q      <= 1'b0;
                        m_address_q    <= '0;
                        m_writedata_q  <= '0;
                        aborted_q      <= abort;
                        if (state_q == S_WRITE) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else begin
                        remain_q      <= remain_q - (ADDR_W+1)'(1);
                        m_address_q   <= m_address_q + ADDR_W'(1);
                        pat_q         <= pat_q + DATA_W'(1);
                        m_writedata_q <= (state_q == S_WRITE) ? pat_q + DATA_W'(1) : '0;
                    end
                end
                S_DRAIN: begin
                    if (!rd_pending) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign err_count       = err_count_q;
    assign first_err_addr  = first_err_addr_q;
    assign first_err_valid = first_err_valid_q;
    assign m_chipselect    = m_chipselect_q;
    assign m_clken         = m_chipselect_q;
    assign m_write         = m_write_q;
    assign m_address       = m_address_q;
    assign m_writedata     = m_writedata_q;
    assign m_byteenable    = '1;

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: RAM slave model, pattern/compare reference model, randomized commands.
module tb_mem_bist_master;
    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_count;
    logic [DW-1:0] cmd_seed;
    logic          abort;
    logic [AW-1:0] m_address;
    logic          m_clken;
    logic          m_chipselect;
    logic          m_write;
    logic [DW-1:0] m_writedata;
    logic [DW/8-1:0] m_byteenable;
    logic [DW-1:0] m_readdata;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic          first_err_valid;

    always #5 clk = ~clk;

    mem_bist_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_count(cmd_count), .cmd_seed(cmd_seed),
        .abort(abort),
        .m_address(m_address), .m_clken(m_clken), .m_chipselect(m_chipselect),
        .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_readdata(m_readdata),
        .busy(busy), .done(done), .aborted(aborted), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_valid(first_err_valid)
    );

    // RAM slave with RD_LAT read latency; corrupt_* lets the bench poke a word while idle.
    logic [DW-1:0] ram   [DEPTH];
    logic [DW-1:0] rd_sh [RD_LAT];
    logic          corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    logic [DW-1:0] corrupt_data = '0;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_chipselect && m_write) ram[m_address] <= m_writedata;
        else if (corrupt_en) ram[corrupt_addr] <= corrupt_data;
        if (m_chipselect && !m_write) rd_sh[0] <= ram[m_address];
        for (int k = 1; k < RD_LAT; k++) rd_sh[k] <= rd_sh[k-1];
    end
    assign m_readdata = rd_sh[RD_LAT-1];

    logic [DW-1:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic corrupt(input int a);
        logic [DW-1:0] d;
        d = ref_mem[a] ^ (32'h1 << $urandom_range(0, 31));
        @(negedge clk);
        corrupt_en = 1'b1; corrupt_addr = AW'(a); corrupt_data = d;
        @(negedge clk);
        corrupt_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic chk_ram();
        int bad = 0;
        for (int a = 0; a < DEPTH; a++) if (ram[a] !== ref_mem[a]) bad++;
        chk("ram_contents_bad_words", 64'(bad), 64'd0);
    endtask

    // abort_at < 1 means no abort; cmd_valid is held high until done to exercise overlap rejection.
    task automatic run_cmd(input bit op, input int base, input int cnt,
                           input logic [DW-1:0] seed, input int abort_at);
        int t0, k, words, exp_done, nacc, done_k, bad_idle, bad_acc, exp_err, a;
        bit exp_ab, exp_fv;
        logic [AW-1:0] exp_fa;
        logic ab_obs, fv_obs;
        logic [AW:0] err_obs;
        logic [AW-1:0] fa_obs;
        exp_ab   = (abort_at >= 1) && (abort_at <= cnt);
        words    = exp_ab ? abort_at : cnt;
        exp_done = (cnt == 0) ? 1 : (op == 1'b0) ? words + 1 : words + RD_LAT + 1;
        exp_err = 0; exp_fv = 1'b0; exp_fa = '0;
        if (op) begin
            for (int i = 0; i < words; i++) begin
                a = (base + i) % DEPTH;
                if (ref_mem[a] !== seed + DW'(i)) begin
                    exp_err++;
                    if (!exp_fv) begin exp_fv = 1'b1; exp_fa = AW'(a); end
                end
            end
        end
        chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_base = AW'(base);
        cmd_count = (AW+1)'(cnt); cmd_seed = seed;
        t0 = cyc; nacc = 0; done_k = -1; bad_idle = 0; bad_acc = 0;
        ab_obs = 1'b0; fv_obs = 1'b0; err_obs = '0; fa_obs = '0;
        @(negedge clk);
        while (done_k < 0 && (cyc - t0) < 1200) begin
            k = cyc - t0;
            if (m_clken !== m_chipselect || m_byteenable !== '1) bad_idle++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) bad_idle++;
            if (m_chipselect === 1'b1) begin
                if (m_address !== AW'((base + nacc) % DEPTH)) bad_acc++;
                if (m_write !== !op) bad_acc++;
                if (m_writedata !== (op ? DW'(0) : seed + DW'(nacc))) bad_acc++;
                if (k != nacc + 1) bad_acc++;
                nacc++;
            end else if (m_address !== '0 || m_writedata !== '0 || m_write !== 1'b0) begin
                bad_idle++;
            end
            if (done === 1'b1) begin
                done_k = k; ab_obs = aborted; err_obs = err_count;
                fv_obs = first_err_valid; fa_obs = first_err_addr;
                cmd_valid = 1'b0; abort = 1'b0;
            end else begin
                abort = (k == abort_at);
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0; abort = 1'b0;
        chk("done_cycle", 64'(done_k), 64'(exp_done));
        chk("access_count", 64'(nacc), 64'(words));
        chk("access_fields_bad", 64'(bad_acc), 64'd0);
        chk("idle_bus_status_bad", 64'(bad_idle), 64'd0);
        chk("aborted", 64'(ab_obs), 64'(exp_ab));
        if (op) begin
            chk("err_count", 64'(err_obs), 64'(exp_err));
            chk("first_err_valid", 64'(fv_obs), 64'(exp_fv));
            if (exp_fv) chk("first_err_addr", 64'(fa_obs), 64'(exp_fa));
        end
        @(negedge clk);
        chk("ready_after_done", 64'(cmd_ready), 64'd1);
        chk("done_single_pulse", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
        if (op) chk("err_count_hold", 64'(err_count), 64'(exp_err));
        if (!op) for (int i = 0; i < words; i++) ref_mem[(base + i) % DEPTH] = seed + DW'(i);
        $display("cmd op=%0s base=%03h count=%0d seed=%08h abort_at=%0d done_at=%0d accesses=%0d errs=%0d aborted=%0d",
                 op ? "CHECK" : "FILL", base, cnt, seed, abort_at, done_k, nacc, err_obs, ab_obs);
    endtask

    initial begin
        int base, cnt, ab, nd;
        logic [DW-1:0] seed;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0;
        cmd_count = '0; cmd_seed = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bus", {m_chipselect, m_clken, m_write, m_address, m_writedata}, 64'd0);
        chk("rst_byteenable", 64'(m_byteenable), 64'hF);
        chk("rst_status", {aborted, err_count, first_err_addr, first_err_valid}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_cmd(1'b0, 0, 4, 32'h1000_0000, 0);
        run_cmd(1'b1, 0, 4, 32'h1000_0000, 0);
        corrupt(2);
        run_cmd(1'b1, 0, 4, 32'h1000_0000, 0);
        run_cmd(1'b0, 'h3FE, 4, 32'hCAFE_0000, 0);
        run_cmd(1'b0, $urandom_range(0, DEPTH-1), DEPTH, $urandom, 0);
        chk_ram();
        run_cmd(1'b1, $urandom_range(0, DEPTH-1), 100, $urandom, 10);
        run_cmd(1'b1, 5, 0, 32'h0, 0);
        run_cmd(1'b0, 7, 0, 32'h0, 1);

        for (int it = 0; it < 8; it++) begin
            base = $urandom_range(0, DEPTH-1);
            cnt  = $urandom_range(1, 40);
            seed = $urandom;
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cnt) : 0;
            run_cmd(1'b0, base, cnt, seed, ab);
            if ($urandom_range(0, 1) == 1) corrupt((base + $urandom_range(0, cnt-1)) % DEPTH);
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, cnt) : 0;
            run_cmd(1'b1, base, cnt, seed, ab);
        end
        chk_ram();

        // Reset asserted in cycle 3 of a FILL: two writes land, bus drops at once, no done.
        base = $urandom_range(0, DEPTH-1);
        seed = $urandom;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = AW'(base);
        cmd_count = (AW+1)'(20); cmd_seed = seed;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_strobe", 64'(m_chipselect), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_async_strobe", 64'(m_chipselect), 64'd0);
        chk("reset_async_ready", 64'(cmd_ready), 64'd1);
        nd = 0;
        repeat (3) begin @(negedge clk); if (done === 1'b1) nd++; end
        reset_n = 1'b1;
        repeat (3) begin @(negedge clk); if (done === 1'b1) nd++; end
        chk("reset_no_done", 64'(nd), 64'd0);
        ref_mem[base % DEPTH]       = seed;
        ref_mem[(base + 1) % DEPTH] = seed + 32'd1;
        $display("cmd op=FILL base=%03h count=20 seed=%08h interrupted by reset in cycle 3", base, seed);
        chk_ram();
        run_cmd(1'b1, base, 6, seed, 0);
        run_cmd(1'b1, base, 2, seed, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bist_master.md
# mem_bist_master

Avalon-MM master that drives the single-port on-chip RAM slave (10-bit word address, 32-bit data, byte enables, read latency 1) to fill a range with a deterministic pattern or read it back and check it. Sits beside the RAM on the system interconnect as a self-test and initialisation engine. It accepts one command at a time through a valid/ready handshake, issues one bus access per cycle, and reports an error count and the first failing address.

## Interface

- ADDR_W, 10, word address width; range length is up to 2^ADDR_W words.
- DATA_W, 32, data width; must be a multiple of 8.
- RD_LAT, 1, slave read latency in cycles; legal values are 1 and 2.
- clk  in  1  single clock for the block and the slave.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = FILL, 1 = CHECK.
- cmd_base  in  ADDR_W  first word address.
- cmd_count  in  ADDR_W+1  number of words, 0..2^ADDR_W.
- cmd_seed  in  DATA_W  pattern seed.
- abort  in  1  stop issuing accesses; sampled in WRITE and READ only.
- m_address  out  ADDR_W  slave address.
- m_clken  out  1  equal to m_chipselect.
- m_chipselect  out  1  access strobe.
- m_write  out  1  1 = write, 0 = read (when selected).
- m_writedata  out  DATA_W  write data.
- m_byteenable  out  DATA_W/8  constant all-ones.
- m_readdata  in  DATA_W  slave read data.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse at command completion.
- aborted  out  1  valid with done; set when the command ended by abort.
- err_count  out  ADDR_W+1  CHECK mismatches; cleared on command accept.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_valid  out  1  set at the first mismatch; cleared on accept.

## Operation

- **Pattern.** Word i (0-based) has address (cmd_base + i) mod 2^ADDR_W, with wrap-around at the top of memory. Its data is (cmd_seed + i) mod 2^DATA_W.
- **Command capture.** The handshake completes when cmd_valid && cmd_ready. On that cycle the block latches op, base, count and seed, clears err_count, first_err_valid and aborted, and leaves IDLE.
- **States:** IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE -> DONE when count = 0.
  - IDLE -> WRITE when op = FILL.
  - IDLE -> READ when op = CHECK.
  - WRITE: one write per cycle (m_chipselect = m_write = 1). After the last word or on abort -> DONE.
  - READ: one read per cycle. Each issued read pushes its expected data and address into an RD_LAT-deep shift pipeline. After the last word or on abort -> DRAIN.
  - DRAIN: no new accesses. Stays until all outstanding reads have returned and been compared -> DONE.
  - DONE: done = 1 for one cycle -> IDLE.
- **Abort.** When abort is high in a WRITE or READ cycle, that cycle's access is still issued. It is the last access. aborted = 1 at done.
- **Compare.** When m_readdata != expected: err_count += 1. If first_err_valid = 0, capture the address and set first_err_valid. err_count cannot overflow because the maximum is 2^ADDR_W.
- **Status hold.** err_count, first_err_addr, first_err_valid and aborted hold their values until the next accept.
- **Idle bus.** With no access in progress, m_chipselect, m_write and m_clken are 0, and m_address and m_writedata are 0.
- **Reset values.** Every output is 0 except m_byteenable (all ones) and cmd_ready (1). State is IDLE.
- **Reset mid-command.** Asserting reset during a command abandons it immediately: no done pulse, and the bus goes idle asynchronously.

## Timing

- Accept at cycle 0. The first access is on the bus at cycle 1.
- **FILL, N words.** Writes occupy cycles 1..N. done is at cycle N+1. cmd_ready returns at N+2.
- **CHECK, N words.** Reads occupy cycles 1..N. Read k, issued at cycle k, is compared on the edge ending cycle k+RD_LAT. done is at cycle N+RD_LAT+1. err_count is final in the done cycle.
- **count = 0.** done at cycle 1 with no bus access.
- **Abort.** Abort seen at cycle j gives done at j+1 for FILL and j+RD_LAT+1 for CHECK.
- **Command overlap.** cmd_valid held high during busy is ignored. Back-to-back commands are separated by at least one IDLE cycle.

## Test plan

- FILL base=0x000, count=4, seed=0x1000_0000 -> writes at cycles 1-4 to addresses 0-3 with data 0x1000_0000..0x1000_0003. done at cycle 5.
- CHECK of the same range against a correct RAM model -> 4 reads, err_count=0, first_err_valid=0, done at cycle 4+RD_LAT+1.
- Corrupt word 2 (address 0x002) in the model, then CHECK -> err_count=1, first_err_addr=0x002, first_err_valid=1.
- FILL base=0x3FE, count=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 (wrap). Then FILL count=1024 -> done at cycle 1025.
- CHECK count=100 with abort at cycle 10 -> 10 reads, done at cycle 10+RD_LAT+1, aborted=1, no access after cycle 10. A command with count=0 -> done at cycle 1 with no strobe.
- reset_n low at cycle 3 of a FILL -> m_chipselect drops immediately, no done pulse. After release, cmd_ready=1 and a new CHECK runs normally.
